// File: rtl/clock_pkg.sv
// clock_pkg: shared alarm state encoding and time field widths/limits
package clock_pkg;
   typedef enum logic [1:0] {DISARMED, ARMED, RINGING, WAIT} al_state_t;
   localparam int SEC_W = 6;
   localparam int MIN_W = 6;
   localparam int HRS_W = 4;
   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
   localparam logic [HRS_W-1:0] HRS_MAX = 4'd11;
endpackage

// File: rtl/tone_divider.sv
// tone_divider: square wave toggling every DIV enabled cycles
// Ports: clk; i_en counts one step; i_clr zeroes count and output (wins over i_en); o_out square wave
module tone_divider #(
   parameter int DIV = 5000
) (
   input  logic clk,
   input  logic i_en,
   input  logic i_clr,
   output logic o_out
);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   logic [CW-1:0] r_cnt;
   logic          r_out;
   always_ff @(posedge clk)
      if (i_clr) begin
         r_cnt <= '0;
         r_out <= 1'b0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
         r_out <= (r_cnt == LAST) ? ~r_out : r_out;
      end
   assign o_out = r_out;
endmodule

// File: rtl/timekeeping_controller.sv
// timekeeping_controller: time-of-day / alarm registers, alarm FSM and buzzer drive
// Ports: clk, reset (sync, active high); tick_1hz, sec/min/hrs_adj, al_adj, al_toggle one-cycle pulses;
//        seconds/minutes/hours, al_minutes/al_hours time fields; al_on armed, alarm ringing, buzzer_out tone
module timekeeping_controller
   import clock_pkg::*;
#(
   parameter int CLK_HZ       = 31500000,
   parameter int TONE_HZ      = 3150,
   parameter int RING_SECONDS = 60,
   parameter int AL_MIN_STEP  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_1hz,
   input  logic             sec_adj,
   input  logic             min_adj,
   input  logic             hrs_adj,
   input  logic             al_adj,
   input  logic             al_toggle,
   output logic [SEC_W-1:0] seconds,
   output logic [MIN_W-1:0] minutes,
   output logic [HRS_W-1:0] hours,
   output logic [MIN_W-1:0] al_minutes,
   output logic [HRS_W-1:0] al_hours,
   output logic             al_on,
   output logic             alarm,
   output logic             buzzer_out
);
   localparam int RW = $clog2(RING_SECONDS + 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
   logic [SEC_W-1:0] r_sec;
   logic [MIN_W-1:0] r_min, r_al_min, w_al_sub;
   logic [HRS_W-1:0] r_hrs, r_al_hrs;
   logic [MIN_W:0]   w_al_sum;
   logic [RW-1:0]    r_ring;
   logic             r_al_on, r_alarm, w_carry_m, w_carry_h, w_al_wrap, w_match;
   al_state_t        r_state, w_nxt;
   // Carries come from the tick only; OR-ing them with the adjust caps each field at +1 per cycle
   assign w_carry_m = tick_1hz && (r_sec == SEC_MAX);
   assign w_carry_h = w_carry_m && (r_min == MIN_MAX);
   assign w_al_sum  = {1'b0, r_al_min} + (MIN_W+1)'(AL_MIN_STEP);
   assign w_al_wrap = w_al_sum > {1'b0, MIN_MAX};
   assign w_al_sub  = w_al_sum[MIN_W-1:0] - (MIN_MAX + 1'b1);
   assign w_match   = (r_hrs == r_al_hrs) && (r_min == r_al_min);
   always_ff @(posedge clk)
      if (reset) begin
         r_sec    <= '0;
         r_min    <= '0;
         r_hrs    <= '0;
         r_al_min <= '0;
         r_al_hrs <= '0;
      end else begin
         if (tick_1hz || sec_adj) r_sec <= (r_sec == SEC_MAX) ? '0 : r_sec + 1'b1;
         if (w_carry_m || min_adj) r_min <= (r_min == MIN_MAX) ? '0 : r_min + 1'b1;
         if (w_carry_h || hrs_adj) r_hrs <= (r_hrs == HRS_MAX) ? '0 : r_hrs + 1'b1;
         if (al_adj) r_al_min <= w_al_wrap ? w_al_sub : w_al_sum[MIN_W-1:0];
         if (al_adj && w_al_wrap) r_al_hrs <= (r_al_hrs == HRS_MAX) ? '0 : r_al_hrs + 1'b1;
      end
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         DISARMED: w_nxt = al_toggle ? ARMED : DISARMED;
         ARMED:    w_nxt = al_toggle ? DISARMED : w_match ? RINGING : ARMED;
         RINGING:  w_nxt = al_toggle ? DISARMED : (tick_1hz && r_ring == RING_LAST) ? WAIT : RINGING;
         WAIT:     w_nxt = al_toggle ? DISARMED : w_match ? WAIT : ARMED;
         default:  w_nxt = ARMED;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         r_state <= ARMED;
         r_al_on <= 1'b1;
         r_alarm <= 1'b0;
         r_ring  <= '0;
      end else begin
         r_state <= w_nxt;
         r_al_on <= w_nxt != DISARMED;
         r_alarm <= w_nxt == RINGING;
         r_ring  <= (r_state != RINGING) ? '0 : r_ring + RW'(tick_1hz);
      end
   // Clear looks at the next state so the buzzer drops on the same edge that leaves RINGING
   tone_divider #(.DIV(CLK_HZ / (2 * TONE_HZ))) u_tone (
      .clk   (clk),
      .i_en  (r_state == RINGING),
      .i_clr (reset || w_nxt != RINGING),
      .o_out (buzzer_out)
   );
   assign seconds    = r_sec;
   assign minutes    = r_min;
   assign hours      = r_hrs;
   assign al_minutes = r_al_min;
   assign al_hours   = r_al_hrs;
   assign al_on      = r_al_on;
   assign alarm      = r_alarm;
endmodule

// File: tb/tb_timekeeping_controller.sv
// tb_timekeeping_controller: directed self-checking bench for timekeeping_controller
module tb_timekeeping_controller;
   logic       clk = 0, reset = 1, tick_1hz = 0, sec_adj = 0, min_adj = 0, hrs_adj = 0;
   logic       al_adj = 0, al_toggle = 0;
   logic [5:0] seconds, minutes, al_minutes;
   logic [3:0] hours, al_hours;
   logic       al_on, alarm, buzzer_out;
   int         n_chk = 0, n_err = 0;
   timekeeping_controller dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .sec_adj(sec_adj), .min_adj(min_adj),
      .hrs_adj(hrs_adj), .al_adj(al_adj), .al_toggle(al_toggle), .seconds(seconds),
      .minutes(minutes), .hours(hours), .al_minutes(al_minutes), .al_hours(al_hours),
      .al_on(al_on), .alarm(alarm), .buzzer_out(buzzer_out)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic check_time(input string tag, input int h, input int m, input int s);
      check({tag, "_hrs"}, 32'(hours), h);
      check({tag, "_min"}, 32'(minutes), m);
      check({tag, "_sec"}, 32'(seconds), s);
   endtask
   task automatic check_al(input string tag, input int h, input int m);
      check({tag, "_al_hrs"}, 32'(al_hours), h);
      check({tag, "_al_min"}, 32'(al_minutes), m);
   endtask
   initial begin
      step(2);
      check_time("rst", 0, 0, 0);
      check_al("rst", 0, 0);
      check("rst_al_on", 32'(al_on), 1);
      check("rst_alarm", 32'(alarm), 0);
      check("rst_buzz", 32'(buzzer_out), 0);
      reset = 0;
      step(1);
      check("poweron_ring", 32'(alarm), 1);
      al_toggle = 1; step(1); al_toggle = 0;
      check("poweron_cancel", 32'(alarm), 0);
      check("poweron_disarm", 32'(al_on), 0);
      hrs_adj = 1; step(11); hrs_adj = 0;
      min_adj = 1; step(59); min_adj = 0;
      sec_adj = 1; step(58); sec_adj = 0;
      check_time("set", 11, 59, 58);
      tick_1hz = 1; step(1);
      check_time("tick1", 11, 59, 59);
      step(1); tick_1hz = 0;
      check_time("ripple", 0, 0, 0);
      sec_adj = 1; step(10);
      tick_1hz = 1; step(1); tick_1hz = 0; sec_adj = 0;
      check("coll_sec", 32'(seconds), 11);
      min_adj = 1; step(5); min_adj = 0;
      sec_adj = 1; step(48); sec_adj = 0;
      check_time("pre_coll", 0, 5, 59);
      tick_1hz = 1; min_adj = 1; step(1); tick_1hz = 0; min_adj = 0;
      check_time("coll_min", 0, 6, 0);
      tick_1hz = 1; hrs_adj = 1; step(1); tick_1hz = 0; hrs_adj = 0;
      check_time("tick_hrsadj", 1, 6, 1);
      al_adj = 1; step(23); al_adj = 0;
      check_al("al350", 3, 50);
      al_adj = 1; step(1); al_adj = 0;
      check_al("al400", 4, 0);
      al_adj = 1; step(47); al_adj = 0;
      check_al("al1150", 11, 50);
      al_adj = 1; step(1); al_adj = 0;
      check_al("al000", 0, 0);
      al_adj = 1; step(6); al_adj = 0;
      check_al("al100", 1, 0);
      al_toggle = 1; step(1); al_toggle = 0;
      check("arm_al_on", 32'(al_on), 1);
      min_adj = 1; step(54); min_adj = 0;
      check_time("at_alarm", 1, 0, 1);
      check("match_lat", 32'(alarm), 0);
      step(1);
      check("ring", 32'(alarm), 1);
      step(4999);
      check("buzz_lo", 32'(buzzer_out), 0);
      step(1);
      check("buzz_hi", 32'(buzzer_out), 1);
      step(4999);
      check("buzz_hold", 32'(buzzer_out), 1);
      step(1);
      check("buzz_lo2", 32'(buzzer_out), 0);
      tick_1hz = 1; step(59); tick_1hz = 0;
      check_time("ring59", 1, 1, 0);
      check("ring59_alarm", 32'(alarm), 1);
      min_adj = 1; step(59); min_adj = 0;
      check("ring_timechg", 32'(alarm), 1);
      tick_1hz = 1; step(1); tick_1hz = 0;
      check_time("ring60", 1, 0, 1);
      check("timeout_alarm", 32'(alarm), 0);
      check("timeout_al_on", 32'(al_on), 1);
      check("timeout_buzz", 32'(buzzer_out), 0);
      step(3);
      check("wait_hold", 32'(alarm), 0);
      min_adj = 1; step(60); min_adj = 0;
      check("rearm_pre", 32'(alarm), 0);
      step(1);
      check("rearm_ring", 32'(alarm), 1);
      step(5000);
      check("cancel_pre_buzz", 32'(buzzer_out), 1);
      al_toggle = 1; step(1); al_toggle = 0;
      check("cancel_alarm", 32'(alarm), 0);
      check("cancel_al_on", 32'(al_on), 0);
      check("cancel_buzz", 32'(buzzer_out), 0);
      al_toggle = 1; step(1);
      check("retoggle_al_on", 32'(al_on), 1);
      check("retoggle_alarm", 32'(alarm), 0);
      step(1); al_toggle = 0;
      check("toggle_prio_al_on", 32'(al_on), 0);
      check("toggle_prio_alarm", 32'(alarm), 0);
      al_toggle = 1; step(1); al_toggle = 0;
      step(1);
      check("ring3", 32'(alarm), 1);
      step(5000);
      check("pre_rst_buzz", 32'(buzzer_out), 1);
      reset = 1; step(1);
      check_time("midrst", 0, 0, 0);
      check_al("midrst", 0, 0);
      check("midrst_alarm", 32'(alarm), 0);
      check("midrst_buzz", 32'(buzzer_out), 0);
      check("midrst_al_on", 32'(al_on), 1);
      reset = 0; step(1);
      check("post_rst_ring", 32'(alarm), 1);
      al_toggle = 1; step(1); al_toggle = 0;
      check("post_rst_cancel", 32'(alarm), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
